// File: rtl/jpeg_rle_decoder.sv
// Zig-zag run-length expander: turns (run, value), ZRL and EOB symbols back into
// 64 coefficients per 8x8 block, one coefficient per cycle with valid/ready on both sides.
module jpeg_rle_decoder #(
  parameter int COEF_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_run,
  input  logic signed [COEF_W-1:0] in_value,
  input  logic                     in_eob,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [COEF_W-1:0] out_coef,
  output logic [5:0]               out_index,
  output logic                     out_last,
  output logic                     err,
  input  logic                     err_clr,
  output logic [CNT_W-1:0]         block_cnt
);

  typedef enum logic [1:0] {ACCEPT, ZEROS, VALUE, FILL} state_t;

  state_t                     state, state_next;
  logic [5:0]                 idx, idx_next;
  logic [4:0]                 rem, rem_next;
  logic                       zrl_mode, zrl_mode_next;
  logic signed [COEF_W-1:0]   held, held_next;
  logic                       adv, accept, is_zrl;
  logic                       emit, err_set;
  logic signed [COEF_W-1:0]   emit_coef;
  logic [6:0]                 reach;

  assign adv      = !out_valid || out_ready;
  assign in_ready = rst_n && (state == ACCEPT) && adv;
  assign accept   = in_valid && in_ready;
  assign is_zrl   = (in_run == 4'd15) && (in_value == '0);
  // Position one past the last zero of the run; anything above 63 overflows the block
  assign reach    = {1'b0, idx} + (is_zrl ? 7'd16 : {3'b000, in_run});

  // The first coefficient of every symbol is emitted in its accept cycle so that
  // back-to-back symbols stream without bubbles; later ones come from ZEROS/VALUE/FILL.
  always_comb begin
    state_next    = state;
    rem_next      = rem;
    zrl_mode_next = zrl_mode;
    held_next     = held;
    emit          = 1'b0;
    emit_coef     = '0;
    err_set       = 1'b0;
    case (state)
      ACCEPT: begin
        if (accept) begin
          if (in_eob) begin
            if (idx == 6'd0) begin
              err_set = 1'b1;
            end else begin
              emit = 1'b1;
              if (idx != 6'd63) state_next = FILL;
            end
          end else if (idx == 6'd0) begin
            // DC position cannot carry a run: drop the run, keep the value
            emit      = 1'b1;
            emit_coef = in_value;
            if (in_run != 4'd0) err_set = 1'b1;
          end else if (reach > 7'd63) begin
            err_set = 1'b1;
            emit    = 1'b1;
            if (idx != 6'd63) state_next = FILL;
          end else if (is_zrl) begin
            emit          = 1'b1;
            rem_next      = 5'd15;
            zrl_mode_next = 1'b1;
            state_next    = ZEROS;
          end else if (in_run == 4'd0) begin
            emit      = 1'b1;
            emit_coef = in_value;
          end else begin
            emit          = 1'b1;
            held_next     = in_value;
            zrl_mode_next = 1'b0;
            if (in_run == 4'd1) begin
              state_next = VALUE;
            end else begin
              rem_next   = {1'b0, in_run - 4'd1};
              state_next = ZEROS;
            end
          end
        end
      end
      ZEROS: begin
        if (adv) begin
          emit     = 1'b1;
          rem_next = rem - 5'd1;
          if (rem == 5'd1) state_next = zrl_mode ? ACCEPT : VALUE;
        end
      end
      VALUE: begin
        if (adv) begin
          emit       = 1'b1;
          emit_coef  = held;
          state_next = ACCEPT;
        end
      end
      FILL: begin
        if (adv) begin
          emit = 1'b1;
          if (idx == 6'd63) state_next = ACCEPT;
        end
      end
      default: state_next = ACCEPT;
    endcase
  end

  assign idx_next = emit ? idx + 6'd1 : idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCEPT;
      idx      <= '0;
      rem      <= '0;
      zrl_mode <= 1'b0;
      held     <= '0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      rem      <= rem_next;
      zrl_mode <= zrl_mode_next;
      held     <= held_next;
    end
  end

  // Output register only moves when downstream can take a new beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_coef  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (adv) begin
      out_valid <= emit;
      if (emit) begin
        out_coef  <= emit_coef;
        out_index <= idx;
        out_last  <= (idx == 6'd63);
      end
    end
  end

  // A clear in the same cycle as a new error wins, so that error is lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err       <= 1'b0;
      block_cnt <= '0;
    end else begin
      err <= err_clr ? 1'b0 : (err | err_set);
      if (emit && (idx == 6'd63)) block_cnt <= block_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_jpeg_rle_decoder.sv
// Bench for jpeg_rle_decoder: symbol-level expansion model feeding a scoreboard that is
// checked on every output handshake, plus literal checks on recorded block contents.
module tb_jpeg_rle_decoder;

  localparam int COEF_W = 12;
  localparam int CNT_W  = 16;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic [3:0]               in_run;
  logic signed [COEF_W-1:0] in_value;
  logic                     in_eob;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [COEF_W-1:0] out_coef;
  logic [5:0]               out_index;
  logic                     out_last;
  logic                     err;
  logic                     err_clr;
  logic [CNT_W-1:0]         block_cnt;

  jpeg_rle_decoder #(.COEF_W(COEF_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_run(in_run),
    .in_value(in_value), .in_eob(in_eob),
    .out_valid(out_valid), .out_ready(out_ready), .out_coef(out_coef),
    .out_index(out_index), .out_last(out_last),
    .err(err), .err_clr(err_clr), .block_cnt(block_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int coef; int idx; bit last; } exp_t;
  exp_t exp_q[$];

  int  tests = 0;
  int  fails = 0;
  int  m_idx = 0;
  bit  m_err = 1'b0;
  int  m_blocks = 0;
  int  obs[64];
  int  cyc = 0;
  int  first_hs = 0;
  int  last_hs = 0;
  bit  stall_en = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: timed out waiting on DUT", name);
  endtask

  // Spec-level model: each symbol becomes a list of (coef, index, last) entries
  function automatic void modelPush(input int c);
    exp_q.push_back('{c, m_idx, (m_idx == 63)});
    if (m_idx == 63) m_blocks++;
    m_idx = (m_idx + 1) % 64;
  endfunction

  function automatic void modelSymbol(input bit eob, input int run, input int value);
    bit zrl;
    int n;
    zrl = !eob && (run == 15) && (value == 0);
    if (eob) begin
      if (m_idx == 0) m_err = 1'b1;
      else do modelPush(0); while (m_idx != 0);
    end else if (m_idx == 0) begin
      if (run != 0) m_err = 1'b1;
      modelPush(value);
    end else begin
      n = zrl ? 16 : run;
      if (m_idx + n > 63) begin
        m_err = 1'b1;
        do modelPush(0); while (m_idx != 0);
      end else begin
        repeat (n) modelPush(0);
        if (!zrl) modelPush(value);
      end
    end
  endfunction

  function automatic void modelReset();
    exp_q.delete();
    m_idx    = 0;
    m_err    = 1'b0;
    m_blocks = 0;
  endfunction

  function automatic void clearObs();
    for (int i = 0; i < 64; i++) obs[i] = 9999;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the symbol was accepted
  task automatic applyStimulus(input bit eob, input int run, input int value);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_eob   = eob;
    in_run   = 4'(run);
    in_value = COEF_W'(value);
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        modelSymbol(eob, run, value);
        done = 1'b1;
      end
    end
    if (!done) begin
      failNow("accept");
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) failNow("drain");
    @(posedge clk);
    #1;
  endtask

  task automatic pulseErrClr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_coef", $signed(out_coef), 0);
    checkOutput("rst_out_index", out_index, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_block_cnt", block_cnt, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(posedge clk) cyc++;

  // Scoreboard compare plus stall-stability and in_ready checks, every cycle
  logic                     prev_stall = 1'b0;
  logic                     prev_valid, prev_last;
  logic signed [COEF_W-1:0] prev_coef;
  logic [5:0]               prev_index;
  always @(negedge clk) begin
    exp_t e;
    int pending;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_valid", out_valid, prev_valid);
        checkOutput("stall_coef", $signed(out_coef), $signed(prev_coef));
        checkOutput("stall_index", out_index, prev_index);
        checkOutput("stall_last", out_last, prev_last);
      end
      pending = exp_q.size() - int'(out_valid);
      checkOutput("in_ready", in_ready, int'(pending <= 0 && (!out_valid || out_ready)));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out_index", out_index, -1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("out_coef", $signed(out_coef), e.coef);
          checkOutput("out_index", out_index, e.idx);
          checkOutput("out_last", out_last, e.last);
          obs[out_index] = $signed(out_coef);
          if (out_index == 6'd0) first_hs = cyc;
          if (out_last) last_hs = cyc;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_valid = out_valid;
      prev_coef  = out_coef;
      prev_index = out_index;
      prev_last  = out_last;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit hit;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_eob   = 1'b0;
    in_run   = '0;
    in_value = '0;
    err_clr  = 1'b0;
    clearObs();
    applyReset();

    // Block A: DC, one AC, EOB
    applyStimulus(0, 0, 5);
    applyStimulus(0, 0, -3);
    applyStimulus(1, 0, 0);
    waitDrain();
    checkOutput("a_idx0", obs[0], 5);
    checkOutput("a_idx1", obs[1], -3);
    checkOutput("a_idx2", obs[2], 0);
    checkOutput("a_idx63", obs[63], 0);
    checkOutput("a_consecutive", last_hs - first_hs, 63);
    checkOutput("a_block_cnt", block_cnt, 1);
    checkOutput("a_err", err, 0);

    // Block B: runs and ZRL
    clearObs();
    applyStimulus(0, 0, 7);
    applyStimulus(0, 2, 9);
    applyStimulus(0, 15, 0);
    applyStimulus(0, 1, -1);
    applyStimulus(1, 0, 0);
    waitDrain();
    checkOutput("b_idx0", obs[0], 7);
    checkOutput("b_idx1", obs[1], 0);
    checkOutput("b_idx3", obs[3], 9);
    checkOutput("b_idx19", obs[19], 0);
    checkOutput("b_idx20", obs[20], 0);
    checkOutput("b_idx21", obs[21], -1);
    checkOutput("b_idx63", obs[63], 0);
    checkOutput("b_block_cnt", block_cnt, 2);
    checkOutput("b_model_blocks", m_blocks, 2);

    // Block C: 64 explicit coefficients, no EOB, then a new block
    clearObs();
    applyStimulus(0, 0, 1);
    for (int i = 0; i < 63; i++) applyStimulus(0, 0, 1);
    waitDrain();
    checkOutput("c_block_cnt", block_cnt, 3);
    checkOutput("c_err", err, 0);
    checkOutput("c_idx63", obs[63], 1);
    applyStimulus(0, 0, 4);
    applyStimulus(1, 0, 0);
    waitDrain();
    checkOutput("c_new_dc", obs[0], 4);
    checkOutput("c_block_cnt2", block_cnt, 4);

    // Block D: overflow at index 60
    clearObs();
    applyStimulus(0, 0, 2);
    applyStimulus(0, 15, 0);
    applyStimulus(0, 15, 0);
    applyStimulus(0, 15, 0);
    applyStimulus(0, 10, 6);
    applyStimulus(0, 5, 8);
    waitDrain();
    checkOutput("d_idx59", obs[59], 6);
    checkOutput("d_idx60", obs[60], 0);
    checkOutput("d_idx63", obs[63], 0);
    checkOutput("d_err", err, 1);
    checkOutput("d_model_err", m_err, 1);
    checkOutput("d_block_cnt", block_cnt, 5);
    checkOutput("d_model_idx", m_idx, 0);
    pulseErrClr();
    checkOutput("d_err_clr", err, 0);

    // Block E: random backpressure through ZRL runs
    clearObs();
    stall_en = 1'b1;
    applyStimulus(0, 0, 1);
    applyStimulus(0, 15, 0);
    applyStimulus(0, 15, 0);
    applyStimulus(0, 0, 5);
    applyStimulus(1, 0, 0);
    waitDrain();
    stall_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("e_idx33", obs[33], 5);
    checkOutput("e_idx32", obs[32], 0);
    checkOutput("e_block_cnt", block_cnt, 6);
    checkOutput("e_err", err, 0);

    // EOB first after reset, then async reset mid-block
    applyReset();
    applyStimulus(1, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("f_no_output", out_valid, 0);
    checkOutput("f_err", err, 1);
    checkOutput("f_model_err", m_err, 1);
    applyStimulus(0, 0, 3);
    applyStimulus(0, 15, 0);
    applyStimulus(0, 15, 0);
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk);
      if (out_valid && out_index == 6'd30) hit = 1'b1;
    end
    if (!hit) failNow("reach_idx30");
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("g_out_valid", out_valid, 0);
    checkOutput("g_out_index", out_index, 0);
    checkOutput("g_out_last", out_last, 0);
    checkOutput("g_out_coef", $signed(out_coef), 0);
    checkOutput("g_block_cnt", block_cnt, 0);
    checkOutput("g_err", err, 0);
    checkOutput("g_in_ready", in_ready, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clearObs();
    applyStimulus(0, 0, 9);
    applyStimulus(1, 0, 0);
    waitDrain();
    checkOutput("h_idx0", obs[0], 9);
    checkOutput("h_block_cnt", block_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
